// File: rtl/cmd_bus_router.sv
// Command packet router: buffers one input packet, checks its declared
// length and type code, then replays it on the destination port selected
// by that type code. Rejected packets raise an error pulse and are counted.
module cmd_bus_router #(
  parameter int P_PORT_NUM   = 4,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_LEN_WIDTH  = 8,
  parameter int P_PKT_DEPTH  = 64,
  parameter int P_TYPE_IDX   = 1,
  parameter int P_TYPE_BASE  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_DATA_WIDTH-1:0] i_cmd_data,
  input  logic [P_LEN_WIDTH-1:0]  i_cmd_len,
  input  logic                    i_cmd_last,
  input  logic                    i_cmd_valid,
  output logic [P_DATA_WIDTH-1:0] o_port_data,
  output logic [P_LEN_WIDTH-1:0]  o_port_len,
  output logic                    o_port_last,
  output logic [P_PORT_NUM-1:0]   o_port_valid,
  output logic                    o_busy,
  output logic                    o_err_pulse,
  output logic [15:0]             o_drop_cnt
);

  localparam int AW = $clog2(P_PKT_DEPTH);
  localparam int CW = AW + 1;  // counter must be able to hold P_PKT_DEPTH itself
  localparam int PW = $clog2(P_PORT_NUM);
  localparam logic [P_PORT_NUM-1:0]   ONE_HOT_0 = P_PORT_NUM'(1);
  localparam logic [P_DATA_WIDTH-1:0] TYPE_BASE = P_DATA_WIDTH'(P_TYPE_BASE);

  typedef enum logic [1:0] {IDLE, RECV, SEND, DISCARD} state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [P_DATA_WIDTH-1:0] mem [P_PKT_DEPTH];
  logic [CW-1:0]           wr_cnt;
  logic [CW-1:0]           rd_ptr;
  logic [P_LEN_WIDTH-1:0]  len_q;
  logic [P_DATA_WIDTH-1:0] type_q;
  logic [PW-1:0]           port_q;
  logic                    pend;      // a packet started during SEND and has not ended yet
  logic                    pend_nx;
  logic                    armed;     // low only until the first edge after reset release
  logic                    mute;      // swallowing the packet that straddled reset release

  logic                    take;
  logic [CW-1:0]           cur_idx;
  logic [CW-1:0]           cnt_now;
  logic [P_LEN_WIDTH-1:0]  len_now;
  logic [P_DATA_WIDTH-1:0] type_now;
  logic [P_DATA_WIDTH-1:0] port_sel;
  logic                    pkt_ok;
  logic                    issue;
  logic                    accept;
  logic                    drop;

  assign o_busy = (state != IDLE);

  // Datapath view of the word on the input this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    take     = 1'b0;
    cur_idx  = '0;
    len_now  = i_cmd_len;
    if (state == RECV) begin
      cur_idx = wr_cnt;
      len_now = len_q;
    end
    if (i_cmd_valid) begin
      take = (state == RECV) || (state == IDLE && armed && !mute);
    end
    cnt_now  = cur_idx + CW'(1);
    type_now = (32'(cur_idx) == P_TYPE_IDX) ? i_cmd_data : type_q;
    // Unsigned subtraction: a type below the base wraps high and fails the range check.
    port_sel = type_now - TYPE_BASE;
    pkt_ok   = (32'(cnt_now) == 32'(len_now)) &&
               (32'(cnt_now) > P_TYPE_IDX) &&
               (32'(port_sel) < P_PORT_NUM);
    issue    = (state == SEND) && (32'(rd_ptr) < 32'(len_q));
  end

  // Next-state logic plus accept/drop decisions.
  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    accept   = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          if (i_cmd_last) begin
            if (pkt_ok) begin
              accept   = 1'b1;
              state_nx = SEND;
            end else begin
              drop = 1'b1;
            end
          end else begin
            state_nx = RECV;
          end
        end
      end
      RECV: begin
        if (i_cmd_valid) begin
          if (i_cmd_last) begin
            if (pkt_ok) begin
              accept   = 1'b1;
              state_nx = SEND;
            end else begin
              drop     = 1'b1;
              state_nx = IDLE;
            end
          end else if (32'(cnt_now) == P_PKT_DEPTH) begin
            state_nx = DISCARD;
          end
        end
      end
      SEND: begin
        // Words arriving now are never buffered; their packet is dropped once, on its last word.
        if (i_cmd_valid) begin
          if (i_cmd_last) begin
            drop    = 1'b1;
            pend_nx = 1'b0;
          end else begin
            pend_nx = 1'b1;
          end
        end
        if (o_port_last) begin
          state_nx = pend_nx ? DISCARD : IDLE;
          pend_nx  = 1'b0;
        end
      end
      DISCARD: begin
        if (i_cmd_valid && i_cmd_last) begin
          drop     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Packet buffer write port.
  // NOTE: the buffer has no reset; every word is written before it is read back.
  always_ff @(posedge i_clk) begin
    if (take) begin
      mem[cur_idx[AW-1:0]] <= i_cmd_data;
    end
  end

  // Control state, latched header fields, replay outputs and drop accounting.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      wr_cnt       <= '0;
      rd_ptr       <= '0;
      len_q        <= '0;
      type_q       <= '0;
      port_q       <= '0;
      pend         <= 1'b0;
      armed        <= 1'b0;
      mute         <= 1'b0;
      o_port_data  <= '0;
      o_port_len   <= '0;
      o_port_last  <= 1'b0;
      o_port_valid <= '0;
      o_err_pulse  <= 1'b0;
      o_drop_cnt   <= '0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
      armed <= 1'b1;

      if (state == IDLE && i_cmd_valid && (!armed || mute)) begin
        mute <= !i_cmd_last;
      end

      if (take) begin
        wr_cnt <= cnt_now;
        if (state == IDLE) begin
          len_q <= i_cmd_len;
        end
        if (32'(cur_idx) == P_TYPE_IDX) begin
          type_q <= i_cmd_data;
        end
      end

      if (accept) begin
        port_q <= port_sel[PW-1:0];
        rd_ptr <= '0;
      end else if (issue) begin
        rd_ptr <= rd_ptr + CW'(1);
      end

      if (issue) begin
        o_port_data  <= mem[rd_ptr[AW-1:0]];
        o_port_len   <= len_q;
        o_port_last  <= (32'(rd_ptr) + 32'd1 == 32'(len_q));
        o_port_valid <= ONE_HOT_0 << port_q;
      end else begin
        o_port_len   <= '0;
        o_port_last  <= 1'b0;
        o_port_valid <= '0;
      end

      o_err_pulse <= drop;
      if (drop && o_drop_cnt != 16'hFFFF) begin
        o_drop_cnt <= o_drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_bus_router.sv
// Directed testbench for cmd_bus_router at default parameters
// (4 ports, 8-bit words, depth 64, type at word 1, type base 1).
module tb_cmd_bus_router;

  logic       clk;
  logic       rst;
  logic [7:0] cmd_data;
  logic [7:0] cmd_len;
  logic       cmd_last;
  logic       cmd_valid;
  logic [7:0] port_data;
  logic [7:0] port_len;
  logic       port_last;
  logic [3:0] port_valid;
  logic       busy;
  logic       err_pulse;
  logic [15:0] drop_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int exp_drops   = 0;

  logic [7:0] pkt[$];
  logic [7:0] second[$];

  cmd_bus_router dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_data   (cmd_data),
    .i_cmd_len    (cmd_len),
    .i_cmd_last   (cmd_last),
    .i_cmd_valid  (cmd_valid),
    .o_port_data  (port_data),
    .o_port_len   (port_len),
    .o_port_last  (port_last),
    .o_port_valid (port_valid),
    .o_busy       (busy),
    .o_err_pulse  (err_pulse),
    .o_drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word for the next rising edge, return on the following falling edge.
  task automatic drive(input logic [7:0] d, input logic [7:0] len, input logic last);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_len   = len;
    cmd_last  = last;
    @(negedge clk);
  endtask

  task automatic idle_bus();
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] len);
    for (int i = 0; i < pkt.size(); i++) begin
      drive(pkt[i], len, (i == pkt.size() - 1));
    end
    idle_bus();
  endtask

  // Called on the falling edge right after the last input word was sampled.
  task automatic expect_replay(input string tag, input int port, input logic [7:0] len);
    check($sformatf("%s busy T+1", tag), busy, 1);
    check($sformatf("%s no valid T+1", tag), port_valid, 0);
    for (int i = 0; i < pkt.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s valid w%0d", tag, i), port_valid, 32'(1) << port);
      check($sformatf("%s data w%0d", tag, i), port_data, pkt[i]);
      check($sformatf("%s last w%0d", tag, i), port_last, (i == pkt.size() - 1));
      check($sformatf("%s len w%0d", tag, i), port_len, len);
    end
    @(negedge clk);
    check($sformatf("%s valid after", tag), port_valid, 0);
    check($sformatf("%s idle after", tag), busy, 0);
  endtask

  // Called on the falling edge right after the last word of a rejected packet.
  task automatic expect_drop(input string tag, input logic exp_busy);
    exp_drops++;
    check($sformatf("%s err pulse", tag), err_pulse, 1);
    check($sformatf("%s drop cnt", tag), drop_cnt, exp_drops);
    check($sformatf("%s no valid", tag), port_valid, 0);
    check($sformatf("%s busy", tag), busy, exp_busy);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    cmd_data  = '0;
    cmd_len   = '0;

    // Reset state
    @(negedge clk);
    check("rst valid", port_valid, 0);
    check("rst busy", busy, 0);
    check("rst err", err_pulse, 0);
    check("rst drops", drop_cnt, 0);
    check("rst last", port_last, 0);
    check("rst len", port_len, 0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Basic routing: type 02 -> port 1
    pkt = '{8'h55, 8'h02, 8'hAA, 8'hBB};
    send_pkt(8'd4);
    expect_replay("basic", 1, 8'd4);

    // Short packet: declared 5, delivered 4
    pkt = '{8'h10, 8'h02, 8'h11, 8'h12};
    send_pkt(8'd5);
    expect_drop("short", 1'b0);
    @(negedge clk);
    check("short err one cycle", err_pulse, 0);
    check("short no valid later", port_valid, 0);

    // Out-of-range type 07 then type 01 back-to-back
    pkt = '{8'h20, 8'h07, 8'h21};
    send_pkt(8'd3);
    expect_drop("type07", 1'b0);
    pkt = '{8'h30, 8'h01, 8'h31};
    send_pkt(8'd3);
    check("type01 err cleared", err_pulse, 0);
    expect_replay("type01", 0, 8'd3);

    // Type 00 wraps below the base and is rejected
    pkt = '{8'h21, 8'h00, 8'h22};
    send_pkt(8'd3);
    expect_drop("type00", 1'b0);

    // Zero declared length, single word
    pkt = '{8'h02};
    send_pkt(8'd0);
    expect_drop("len0", 1'b0);

    // One-word packet cannot contain the type word
    pkt = '{8'h02};
    send_pkt(8'd1);
    expect_drop("no type word", 1'b0);
    @(negedge clk);

    // Second packet starts during SEND of the first and ends after SEND
    pkt    = '{8'h40, 8'h03, 8'h41, 8'h42};
    second = '{8'h50, 8'h01, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    send_pkt(8'd4);
    check("overlap busy T+1", busy, 1);
    for (int i = 0; i < 7; i++) begin
      drive(second[i], 8'd7, (i == 6));
      if (i < 4) begin
        check($sformatf("overlap valid w%0d", i), port_valid, 4'b0100);
        check($sformatf("overlap data w%0d", i), port_data, pkt[i]);
        check($sformatf("overlap last w%0d", i), port_last, (i == 3));
      end else begin
        check($sformatf("overlap quiet c%0d", i), port_valid, 0);
      end
      check($sformatf("overlap busy c%0d", i), busy, (i < 6));
      check($sformatf("overlap err c%0d", i), err_pulse, (i == 6));
    end
    idle_bus();
    exp_drops++;
    check("overlap drop cnt", drop_cnt, exp_drops);
    @(negedge clk);
    check("overlap single pulse", err_pulse, 0);
    check("overlap drop cnt stable", drop_cnt, exp_drops);

    // 70-word packet overflows the 64-word buffer
    pkt.delete();
    for (int i = 0; i < 70; i++) begin
      pkt.push_back((i == 1) ? 8'h02 : 8'(i));
    end
    for (int i = 0; i < 70; i++) begin
      drive(pkt[i], 8'd70, (i == 69));
      if (i < 69) begin
        check($sformatf("ovf no valid w%0d", i), port_valid, 0);
        check($sformatf("ovf no err w%0d", i), err_pulse, 0);
        check($sformatf("ovf busy w%0d", i), busy, 1);
      end
    end
    idle_bus();
    expect_drop("ovf", 1'b0);
    pkt = '{8'h60, 8'h02, 8'h61};
    send_pkt(8'd3);
    expect_replay("after ovf", 1, 8'd3);

    // Reset in the middle of a replay (type 04 -> port 3, upper boundary)
    pkt = '{8'h70, 8'h04, 8'h71, 8'h72, 8'h73};
    send_pkt(8'd5);
    check("mid rst busy T+1", busy, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mid rst valid w%0d", i), port_valid, 4'b1000);
      check($sformatf("mid rst data w%0d", i), port_data, pkt[i]);
    end
    rst = 1'b1;
    #1;
    exp_drops = 0;
    check("mid rst valid", port_valid, 0);
    check("mid rst busy", busy, 0);
    check("mid rst drops", drop_cnt, 0);
    check("mid rst last", port_last, 0);
    check("mid rst err", err_pulse, 0);
    @(negedge clk);
    check("in rst valid", port_valid, 0);

    // First word lands on the first edge after reset release: whole packet ignored
    rst = 1'b0;
    drive(8'h80, 8'd3, 1'b0);
    drive(8'h02, 8'd3, 1'b0);
    drive(8'h81, 8'd3, 1'b1);
    idle_bus();
    check("release err", err_pulse, 0);
    check("release drops", drop_cnt, 0);
    check("release busy", busy, 0);
    @(negedge clk);
    check("release valid", port_valid, 0);
    check("release err later", err_pulse, 0);

    pkt = '{8'h90, 8'h01};
    send_pkt(8'd2);
    expect_replay("post release", 0, 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
